// File: rtl/alu_exec_stage.sv
// Execute stage in front of a combinational ALU: EX and WB slots, operand forwarding, valid/ready on both sides.
// Optional: define ALU_EXEC_PERF_EN to add saturating retire/stall counters (perf_retired, perf_stall).
module alu_exec_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [3:0]        id_op,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_ans,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic              wb_illegal
`ifdef ALU_EXEC_PERF_EN
  ,
  output logic [15:0]       perf_retired,
  output logic [15:0]       perf_stall
`endif
);

  logic              ex_valid_reg;
  logic [3:0]        ex_op_reg;
  logic [REG_AW-1:0] ex_rd_reg;
  logic [DATA_W-1:0] ex_a_reg;
  logic [DATA_W-1:0] ex_b_reg;

  logic              wb_valid_reg;
  logic [REG_AW-1:0] wb_rd_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic              wb_we_reg;
  logic              wb_illegal_reg;

  logic ex_legal;
  logic ex_adv;
  logic accept;

  logic [1:0][REG_AW-1:0] src_idx;
  logic [1:0][DATA_W-1:0] src_rf;
  logic [1:0][DATA_W-1:0] src_fwd;
  logic [DATA_W-1:0]      op_b_next;
  logic [DATA_W-1:0]      wb_data_next;
  logic                   wb_we_next;

  assign ex_legal = ~ex_op_reg[3];
  assign ex_adv   = ex_valid_reg & (~wb_valid_reg | wb_ready);
  assign id_ready = ~ex_valid_reg | ex_adv;
  assign accept   = id_valid & id_ready;

  assign src_idx = {id_rt, id_rs};
  assign src_rf  = {id_rt_data, id_rs_data};

  // The EX result is younger than WB, so it wins; an illegal op in EX never forwards.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign src_fwd[gi] =
          (src_idx[gi] == '0)                                      ? '0 :
          (ex_valid_reg && ex_legal && ex_rd_reg == src_idx[gi])   ? alu_ans :
          (wb_valid_reg && wb_we_reg && wb_rd_reg == src_idx[gi])  ? wb_data_reg :
                                                                     src_rf[gi];
    end
  endgenerate

  assign op_b_next    = id_use_imm ? id_imm : src_fwd[1];
  assign wb_data_next = ex_legal ? alu_ans : '0;
  assign wb_we_next   = ex_legal && (ex_rd_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg   <= 1'b0;
      ex_op_reg      <= '0;
      ex_rd_reg      <= '0;
      ex_a_reg       <= '0;
      ex_b_reg       <= '0;
      wb_valid_reg   <= 1'b0;
      wb_rd_reg      <= '0;
      wb_data_reg    <= '0;
      wb_we_reg      <= 1'b0;
      wb_illegal_reg <= 1'b0;
    end else begin
      if (accept) begin
        ex_valid_reg <= 1'b1;
        ex_op_reg    <= id_op;
        ex_rd_reg    <= id_rd;
        ex_a_reg     <= src_fwd[0];
        ex_b_reg     <= op_b_next;
      end else if (ex_adv) begin
        ex_valid_reg <= 1'b0;
      end

      if (ex_adv) begin
        wb_valid_reg   <= 1'b1;
        wb_rd_reg      <= ex_rd_reg;
        wb_data_reg    <= wb_data_next;
        wb_we_reg      <= wb_we_next;
        wb_illegal_reg <= ~ex_legal;
      end else if (wb_ready) begin
        wb_valid_reg <= 1'b0;
      end
    end
  end

  assign alu_a      = ex_a_reg;
  assign alu_b      = ex_b_reg;
  assign alu_op     = ex_op_reg;
  assign wb_valid   = wb_valid_reg;
  assign wb_rd      = wb_rd_reg;
  assign wb_data    = wb_data_reg;
  assign wb_we      = wb_we_reg;
  assign wb_illegal = wb_illegal_reg;

`ifdef ALU_EXEC_PERF_EN
  logic [15:0] perf_retired_reg;
  logic [15:0] perf_stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired_reg <= '0;
      perf_stall_reg   <= '0;
    end else begin
      if (wb_valid_reg && wb_ready && perf_retired_reg != 16'hFFFF)
        perf_retired_reg <= perf_retired_reg + 16'd1;
      if (id_valid && !id_ready && perf_stall_reg != 16'hFFFF)
        perf_stall_reg <= perf_stall_reg + 16'd1;
    end
  end

  assign perf_retired = perf_retired_reg;
  assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: provides the ALU and a register file, and compares against an in-order ISA model.
module tb_alu_exec_stage;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid = 1'b0;
  logic              id_ready;
  logic [3:0]        id_op = '0;
  logic [REG_AW-1:0] id_rd = '0, id_rs = '0, id_rt = '0;
  logic [DATA_W-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic              id_use_imm = 1'b0;
  logic [DATA_W-1:0] alu_a, alu_b, alu_ans;
  logic [3:0]        alu_op;
  logic              wb_valid, wb_we, wb_illegal;
  logic              wb_ready = 1'b1;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
`ifdef ALU_EXEC_PERF_EN
  logic [15:0]       perf_retired, perf_stall;
  int                cnt_ret = 0, cnt_stall = 0;
`endif

  alu_exec_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
    .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ans(alu_ans),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_we(wb_we), .wb_illegal(wb_illegal)
`ifdef ALU_EXEC_PERF_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU; illegal opcodes produce junk that must never reach writeback.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << 1;
      4'd7: r = 16'($signed(a) >>> 1);
      default: r = a ^ b ^ 16'h5A5A;
    endcase
    return r;
  endfunction

  always_comb alu_ans = alu_fn(alu_op, alu_a, alu_b);

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] data;
    logic        we;
    logic        ill;
  } res_t;

  res_t        exp_q[$];
  res_t        ret_log[$];
  bit          wb_full = 1'b0;
  logic [15:0] arch [8];
  logic [15:0] rf [8];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: in-order results in a queue, plus whether the oldest one sits in the WB slot.
  always @(negedge clk) begin : monitor
    bit   ex_full, exp_ready, retire, adv, acc;
    res_t r;
    logic [15:0] a, b;
    if (rst) begin
      exp_q.delete();
      wb_full = 1'b0;
      for (int i = 0; i < 8; i++) arch[i] = rf[i];
`ifdef ALU_EXEC_PERF_EN
      cnt_ret = 0;
      cnt_stall = 0;
`endif
    end else begin
      ex_full   = (exp_q.size() - int'(wb_full)) == 1;
      exp_ready = !ex_full || !wb_full || wb_ready;
      chk("wb_valid", 32'(wb_valid), 32'(wb_full));
      chk("id_ready", 32'(id_ready), 32'(exp_ready));
      if (wb_full) begin
        chk("wb_rd", 32'(wb_rd), 32'(exp_q[0].rd));
        chk("wb_data", 32'(wb_data), 32'(exp_q[0].data));
        chk("wb_we", 32'(wb_we), 32'(exp_q[0].we));
        chk("wb_illegal", 32'(wb_illegal), 32'(exp_q[0].ill));
      end
`ifdef ALU_EXEC_PERF_EN
      chk("perf_retired", 32'(perf_retired), (cnt_ret > 65535) ? 32'd65535 : 32'(cnt_ret));
      chk("perf_stall", 32'(perf_stall), (cnt_stall > 65535) ? 32'd65535 : 32'(cnt_stall));
      if (wb_full && wb_ready) cnt_ret++;
      if (id_valid && !exp_ready) cnt_stall++;
`endif
      if (wb_valid && wb_ready) begin
        ret_log.push_back('{rd: wb_rd, data: wb_data, we: wb_we, ill: wb_illegal});
        $display("retire rd=%0d data=0x%04h we=%0b illegal=%0b", wb_rd, wb_data, wb_we, wb_illegal);
      end
      retire = wb_full && wb_ready;
      adv    = ex_full && (!wb_full || wb_ready);
      acc    = id_valid && exp_ready;
      if (retire) begin
        r = exp_q.pop_front();
        if (r.we) rf[r.rd] = r.data;
      end
      wb_full = adv ? 1'b1 : (retire ? 1'b0 : wb_full);
      if (acc) begin
        a = (id_rs == 3'd0) ? 16'h0 : arch[id_rs];
        b = id_use_imm ? id_imm : ((id_rt == 3'd0) ? 16'h0 : arch[id_rt]);
        r.rd   = id_rd;
        r.ill  = id_op[3];
        r.data = id_op[3] ? 16'h0 : alu_fn(id_op, a, b);
        r.we   = !id_op[3] && (id_rd != 3'd0);
        if (r.we) arch[id_rd] = r.data;
        exp_q.push_back(r);
      end
    end
  end

  task automatic put(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                     input logic [2:0] rt, input logic [15:0] imm, input logic use_imm);
    id_valid   = 1'b1;
    id_op      = op;
    id_rd      = rd;
    id_rs      = rs;
    id_rt      = rt;
    id_imm     = imm;
    id_use_imm = use_imm;
    id_rs_data = (rs == 3'd0) ? 16'($urandom) : rf[rs];
    id_rt_data = (rt == 3'd0) ? 16'($urandom) : rf[rt];
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [15:0] imm, input logic use_imm);
    int waited;
    waited = 0;
    forever begin
      put(op, rd, rs, rt, imm, use_imm);
      @(negedge clk);
      if (id_ready) break;
      waited++;
      if (waited >= 50) begin
        chk("issue_timeout", 32'(id_ready), 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    id_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_reg(input int i, input logic [15:0] v);
    rf[i]   = v;
    arch[i] = v;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) arch[i] = rf[i];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_id_ready", 32'(id_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_illegal", 32'(wb_illegal), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    @(posedge clk); #1;

    // Basic ADD with latency
    set_reg(1, 16'h0003);
    set_reg(2, 16'h0004);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 16'h0, 1'b0);
    @(negedge clk);
    chk("add_lat_n1", 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk("add_lat_n2", 32'(wb_valid), 32'd1);
    chk("add_data", 32'(wb_data), 32'h0007);
    chk("add_rd", 32'(wb_rd), 32'd3);
    chk("add_we", 32'(wb_we), 32'd1);
    @(posedge clk); #1;
    idle(3);

    // Forwarding from EX, then from WB with a bubble
    set_reg(1, 16'h0010);
    set_reg(4, 16'h0001);
    set_reg(2, 16'h0000);
    ret_log.delete();
    issue(4'd0, 3'd2, 3'd1, 3'd4, 16'h0, 1'b0);
    issue(4'd1, 3'd5, 3'd2, 3'd4, 16'h0, 1'b0);
    idle(4);
    chk("fwd_ex_cnt", 32'(ret_log.size()), 32'd2);
    chk("fwd_ex_data", 32'(ret_log[1].data), 32'h0010);
    set_reg(2, 16'h0000);
    ret_log.delete();
    issue(4'd0, 3'd2, 3'd1, 3'd4, 16'h0, 1'b0);
    idle(1);
    issue(4'd1, 3'd5, 3'd2, 3'd4, 16'h0, 1'b0);
    idle(4);
    chk("fwd_wb_cnt", 32'(ret_log.size()), 32'd2);
    chk("fwd_wb_data", 32'(ret_log[1].data), 32'h0010);

    // Backpressure: only two fit while writeback stalls
    ret_log.delete();
    wb_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      put(4'd0, 3'(k + 1), 3'd0, 3'd0, 16'(16'h0100 + k), 1'b1);
      @(negedge clk);
      if (id_ready) k++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", 32'(k), 32'd2);
    @(negedge clk);
    chk("bp_id_ready", 32'(id_ready), 32'd0);
    chk("bp_wb_valid", 32'(wb_valid), 32'd1);
    chk("bp_wb_rd", 32'(wb_rd), 32'd1);
    @(posedge clk); #1;
    wb_ready = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      put(4'd0, 3'(k + 1), 3'd0, 3'd0, 16'(16'h0100 + k), 1'b1);
      @(negedge clk);
      if (id_ready) k++;
      @(posedge clk); #1;
    end
    idle(4);
    chk("bp_retired", 32'(ret_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_order_rd", 32'(ret_log[i].rd), 32'(i + 1));
      chk("bp_order_data", 32'(ret_log[i].data), 32'(16'h0100 + i));
    end

    // Illegal op does not forward; writes to r0 are ignored
    set_reg(5, 16'h1234);
    set_reg(1, 16'h00AA);
    set_reg(2, 16'h0055);
    set_reg(4, 16'h0001);
    ret_log.delete();
    issue(4'd9, 3'd5, 3'd1, 3'd2, 16'h0, 1'b0);
    issue(4'd0, 3'd6, 3'd5, 3'd0, 16'h0, 1'b0);
    issue(4'd0, 3'd0, 3'd1, 3'd4, 16'h0, 1'b0);
    issue(4'd0, 3'd3, 3'd0, 3'd4, 16'h0, 1'b0);
    idle(4);
    chk("ill_cnt", 32'(ret_log.size()), 32'd4);
    chk("ill_flag", 32'(ret_log[0].ill), 32'd1);
    chk("ill_we", 32'(ret_log[0].we), 32'd0);
    chk("ill_data", 32'(ret_log[0].data), 32'h0000);
    chk("ill_no_fwd", 32'(ret_log[1].data), 32'h1234);
    chk("r0_we", 32'(ret_log[2].we), 32'd0);
    chk("r0_read", 32'(ret_log[3].data), 32'h0001);

    // SRA and immediate wrap
    set_reg(1, 16'h8002);
    ret_log.delete();
    issue(4'd7, 3'd3, 3'd1, 3'd2, 16'h0, 1'b0);
    idle(4);
    chk("sra_data", 32'(ret_log[0].data), 32'hC001);
    set_reg(1, 16'h0001);
    issue(4'd0, 3'd3, 3'd1, 3'd0, 16'hFFFF, 1'b1);
    idle(4);
    chk("imm_wrap", 32'(ret_log[1].data), 32'h0000);

    // Reset with both slots full
    wb_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      put(4'd0, 3'd7, 3'd1, 3'd0, 16'(c), 1'b1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("mid_full_ready", 32'(id_ready), 32'd0);
    @(posedge clk); #1;
    id_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_id_ready", 32'(id_ready), 32'd1);
`ifdef ALU_EXEC_PERF_EN
    chk("mid_rst_perf_ret", 32'(perf_retired), 32'd0);
    chk("mid_rst_perf_stall", 32'(perf_stall), 32'd0);
`endif
    @(posedge clk); #1;
    wb_ready = 1'b1;
    ret_log.delete();
    idle(5);
    chk("mid_rst_no_result", 32'(ret_log.size()), 32'd0);

    // Randomised traffic with hazards, stalls and occasional reset
    for (int c = 0; c < 2500; c++) begin
      logic [3:0] op;
      rst = ($urandom_range(0, 599) == 0);
      wb_ready = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7)
        put(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            16'($urandom), 1'($urandom_range(0, 1)));
      else
        id_valid = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    wb_ready = 1'b1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
